// File: rtl/fifo_rdr_pkg.sv
// Shared encodings, sizes and credit helper for sync_fifo_reader and its skid buffer.
package fifo_rdr_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } rdr_state_e;

  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned OCC_W      = 2;

  // A new read is allowed only if, after this cycle's pop, the buffered plus
  // in-flight words leave room for the word being requested.
  function automatic logic credit_ok(input logic [OCC_W-1:0] occ,
                                     input logic             inflight,
                                     input logic             pop);
    logic [OCC_W:0] committed;
    logic [OCC_W:0] limit;
    committed = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
    limit     = {{OCC_W{1'b0}}, pop} + (OCC_W+1)'(SKID_DEPTH - 1);
    return committed <= limit;
  endfunction

endpackage

// File: rtl/fifo_rdr_skid.sv
// Two-entry in-order skid buffer: head is always the oldest word.
module fifo_rdr_skid
  import fifo_rdr_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd,
  output logic [DATA_W-1:0] rdata,
  output logic [OCC_W-1:0]  occ
);

  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [OCC_W-1:0]  occ_q, occ_d;

  // Next-state: pop shifts tail into head, write appends at first free slot.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({wr, rd})
      2'b10: begin
        if (occ_q == '0) head_d = wdata;
        else             tail_d = wdata;
        occ_d = occ_q + 1'b1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 1'b1;
      end
      2'b11: begin
        // Simultaneous pop and write keeps occupancy; order is preserved.
        if (occ_q == OCC_W'(1)) begin
          head_d = wdata;
        end else begin
          head_d = tail_q;
          tail_d = wdata;
        end
      end
      default: ;
    endcase
  end

  // Buffer storage and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign rdata = head_q;
  assign occ   = occ_q;

endmodule

// File: rtl/sync_fifo_reader.sv
// Read-side controller for sync_fifo: pops words and presents them on a valid/ready stream.
// Optional burst mode selected by defining FIFO_RDR_BURST_EN.
module sync_fifo_reader
  import fifo_rdr_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic [CNT_W-1:0]  fifo_cnt,
  output logic              fifo_rd,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  rdr_state_e       state_q, state_d;
  logic             inflight_q;
  logic [OCC_W-1:0] occ;
  logic             pop;
  logic             go_drain;
  logic             rd_allowed;
  logic             stop_drain;

  assign out_valid = (occ != '0);
  assign pop       = out_valid && out_ready;

`ifdef FIFO_RDR_BURST_EN
  localparam int unsigned BCNT_W = $clog2(BURST_LEN + 1);

  logic [BCNT_W-1:0] burst_cnt_q, burst_cnt_d;

  assign go_drain   = !fifo_empty && (fifo_cnt >= CNT_W'(BURST_LEN));
  assign rd_allowed = burst_cnt_q < BCNT_W'(BURST_LEN);
  assign stop_drain = fifo_rd && (burst_cnt_q == BCNT_W'(BURST_LEN - 1));

  // Burst counter: cleared while idle, counts issued reads while draining.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (state_q == ST_IDLE) burst_cnt_d = '0;
    else if (fifo_rd)       burst_cnt_d = burst_cnt_q + 1'b1;
  end

  // Burst counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) burst_cnt_q <= '0;
    else     burst_cnt_q <= burst_cnt_d;
  end
`else
  logic unused_cfg;

  assign go_drain   = !fifo_empty;
  assign rd_allowed = 1'b1;
  assign stop_drain = fifo_empty && !fifo_rd;
  assign unused_cfg = ^fifo_cnt ^ (BURST_LEN == 0);
`endif

  // Read strobe; depends combinationally on out_ready to sustain one word per cycle.
  assign fifo_rd = (state_q == ST_DRAIN) && !fifo_empty && rd_allowed &&
                   credit_ok(occ, inflight_q, pop);

  // FSM next-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (go_drain)   state_d = ST_DRAIN;
      ST_DRAIN: if (stop_drain) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM state and in-flight read tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_rd;
    end
  end

  fifo_rdr_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .wr    (inflight_q),
    .wdata (fifo_data),
    .rd    (pop),
    .rdata (out_data),
    .occ   (occ)
  );

  assign busy = (state_q == ST_DRAIN) || out_valid || inflight_q;

endmodule
